// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencer/arbiter in front of the shared 64-cycle iterative
// unsigned multiplier core. It picks one of two requesters round-robin and
// turns each RV64M multiply (MUL/MULH/MULHSU/MULHU/MULW) into an unsigned
// magnitude multiply. It fixes the sign of the 128-bit product and returns
// the selected half over a valid/ready response port. An accepted operation
// can be cancelled with flush.
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   req{0,1}_valid/_ready             request handshake (ready is combinational)
//   req{0,1}_op/_w/_a/_b/_tag         op code, word flag, rs1, rs2, opaque tag
//   rsp_valid/_ready                  response handshake
//   rsp_data/_src/_tag                result, requester index, echoed tag
//   flush                             cancel the accepted, unresponded op
//   core_mul_valid                    one-cycle start pulse to the core
//   core_multiplicand/_multiplier     operand magnitudes, held until the next accept
//   core_out_valid, core_result_h/_l  core completion and 128-bit unsigned product
module mul_ctrl #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic             req0_w,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic             req1_w,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic             rsp_src,
    output logic [TAG_W-1:0] rsp_tag,
    input  logic             flush,
    output logic             core_mul_valid,
    output logic [XLEN-1:0]  core_multiplicand,
    output logic [XLEN-1:0]  core_multiplier,
    input  logic             core_out_valid,
    input  logic [XLEN-1:0]  core_result_h,
    input  logic [XLEN-1:0]  core_result_l
);
    localparam int unsigned PW = 2 * XLEN;
    localparam int unsigned HW = XLEN / 2;
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef struct packed {
        logic [1:0]       op;
        logic             w;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             running;      // low until the first edge after reset release
    logic             last_src;     // requester served most recently
    logic             grant_c;
    logic             accept_c;
    logic             capture_c;
    req_t             req0_c;
    req_t             req1_c;
    req_t             sel_c;
    logic             neg_a_c;
    logic             neg_b_c;
    logic [XLEN-1:0]  mag_a_c;
    logic [XLEN-1:0]  mag_b_c;
    logic             src_q;
    logic [TAG_W-1:0] tag_q;
    logic [1:0]       op_q;
    logic             w_q;
    logic             neg_a_q;
    logic             neg_b_q;
    logic [PW-1:0]    prod_c;
    logic [XLEN-1:0]  result_c;

    assign req0_c = {req0_op, req0_w, req0_a, req0_b, req0_tag};
    assign req1_c = {req1_op, req1_w, req1_a, req1_b, req1_tag};

    // Round-robin: a lone requester wins; on contention the one not served last wins.
    assign grant_c = (req0_valid && req1_valid) ? ~last_src : req1_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, request readies and datapath strobes.
    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept_c   = 1'b0;
        capture_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (running && !flush && (req0_valid || req1_valid)) begin
                    req0_ready = ~grant_c;
                    req1_ready = grant_c;
                    accept_c   = 1'b1;
                    state_nx   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The start pulse goes out this cycle even when flushed.
                state_nx = flush ? S_DRAIN : S_BUSY;
            end
            S_BUSY: begin
                if (core_out_valid) begin
                    capture_c = !flush;
                    state_nx  = flush ? S_IDLE : S_RESP;
                end else if (flush) begin
                    state_nx = S_DRAIN;
                end
            end
            S_RESP: begin
                if (rsp_ready || flush) begin
                    state_nx = S_IDLE;
                end
            end
            S_DRAIN: begin
                // Let the core finish so it is never restarted mid-run.
                if (core_out_valid) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand selection, sign decode and magnitudes of the granted request.
    always_comb begin
        sel_c   = grant_c ? req1_c : req0_c;
        neg_a_c = ((sel_c.op == OP_MULH) || (sel_c.op == OP_MULHSU)) && sel_c.a[XLEN-1] && !sel_c.w;
        neg_b_c = (sel_c.op == OP_MULH) && sel_c.b[XLEN-1] && !sel_c.w;
        mag_a_c = neg_a_c ? (~sel_c.a + XLEN'(1)) : sel_c.a;
        mag_b_c = neg_b_c ? (~sel_c.b + XLEN'(1)) : sel_c.b;
    end

    // Signed product from the unsigned core result, then pick the requested part.
    always_comb begin
        prod_c = {core_result_h, core_result_l};
        if (neg_a_q ^ neg_b_q) begin
            prod_c = ~prod_c + PW'(1);
        end
        if (w_q) begin
            result_c = {{HW{prod_c[HW-1]}}, prod_c[HW-1:0]};
        end else if (op_q == OP_MUL) begin
            result_c = prod_c[XLEN-1:0];
        end else begin
            result_c = prod_c[PW-1:XLEN];
        end
    end

    // Request latch, core operands, response registers and output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running           <= 1'b0;
            last_src          <= 1'b1;
            src_q             <= 1'b0;
            tag_q             <= '0;
            op_q              <= '0;
            w_q               <= 1'b0;
            neg_a_q           <= 1'b0;
            neg_b_q           <= 1'b0;
            core_multiplicand <= '0;
            core_multiplier   <= '0;
            core_mul_valid    <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_data          <= '0;
            rsp_src           <= 1'b0;
            rsp_tag           <= '0;
        end else begin
            running        <= 1'b1;
            core_mul_valid <= accept_c;
            rsp_valid      <= (state_nx == S_RESP);
            if (accept_c) begin
                last_src          <= grant_c;
                src_q             <= grant_c;
                tag_q             <= sel_c.tag;
                op_q              <= sel_c.op;
                w_q               <= sel_c.w;
                neg_a_q           <= neg_a_c;
                neg_b_q           <= neg_b_c;
                core_multiplicand <= mag_a_c;
                core_multiplier   <= mag_b_c;
            end
            if (capture_c) begin
                rsp_data <= result_c;
                rsp_src  <= src_q;
                rsp_tag  <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Testbench for mul_ctrl: models the 64-cycle multiplier core and checks
// results against a signed-arithmetic reference of the RV64M multiply ops.
`timescale 1ns/1ps
module tb_mul_ctrl;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned TAG_W = 4;
    localparam int CORE_LAT = 65;
    localparam int RSP_LAT  = 67;
    localparam int TMO      = 300;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] v;
    logic [1:0] rdy;
    logic [1:0]       op_i  [2];
    logic             w_i   [2];
    logic [XLEN-1:0]  a_i   [2];
    logic [XLEN-1:0]  b_i   [2];
    logic [TAG_W-1:0] tag_i [2];
    logic             rsp_valid, rsp_ready, rsp_src, flush;
    logic [XLEN-1:0]  rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             core_mul_valid, core_out_valid;
    logic [XLEN-1:0]  core_multiplicand, core_multiplier, core_result_h, core_result_l;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_served = 1;
    int core_cnt = 0;
    int pulses = 0;
    int overlaps = 0;
    logic [127:0] core_prod = '0;

    mul_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v[0]), .req0_ready(rdy[0]), .req0_op(op_i[0]), .req0_w(w_i[0]),
        .req0_a(a_i[0]), .req0_b(b_i[0]), .req0_tag(tag_i[0]),
        .req1_valid(v[1]), .req1_ready(rdy[1]), .req1_op(op_i[1]), .req1_w(w_i[1]),
        .req1_a(a_i[1]), .req1_b(b_i[1]), .req1_tag(tag_i[1]),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_src(rsp_src), .rsp_tag(rsp_tag), .flush(flush),
        .core_mul_valid(core_mul_valid), .core_multiplicand(core_multiplicand),
        .core_multiplier(core_multiplier), .core_out_valid(core_out_valid),
        .core_result_h(core_result_h), .core_result_l(core_result_l)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: result valid for one cycle, 65 cycles after the start pulse.
    always @(posedge clk) begin
        if (!rst_n) begin
            core_cnt <= 0;
        end else if (core_mul_valid) begin
            if (core_cnt != 0) overlaps <= overlaps + 1;
            core_cnt  <= CORE_LAT;
            pulses    <= pulses + 1;
            core_prod <= 128'(core_multiplicand) * 128'(core_multiplier);
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
        end
    end
    assign core_out_valid = (core_cnt == 1);
    assign core_result_h  = core_prod[127:64];
    assign core_result_l  = core_prod[63:0];

    // Reference: sign/zero-extend per op, multiply as 128-bit signed, select.
    function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] o, input logic wd,
                                                input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        logic signed [127:0] sx, sy, p;
        logic [31:0] lo;
        if (wd) begin
            lo = x[31:0] * y[31:0];
            return {{32{lo[31]}}, lo};
        end
        sx = (o == 2'b01 || o == 2'b10) ? {{64{x[63]}}, x} : {64'b0, x};
        sy = (o == 2'b01) ? {{64{y[63]}}, y} : {64'b0, y};
        p  = sx * sy;
        return (o == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    function automatic logic [XLEN-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 64'h0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'($urandom_range(0, 9));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic rand_req(input int s);
        op_i[s]  = 2'($urandom_range(0, 3));
        w_i[s]   = ($urandom_range(0, 3) == 0);
        a_i[s]   = rand_operand();
        b_i[s]   = rand_operand();
        tag_i[s] = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_accept(input int s, output int t, output logic ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (v[s] && rdy[s]) begin
                t  = cyc;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_rsp(output int t, output logic ok, output logic leak);
        ok   = 1'b0;
        leak = 1'b0;
        t    = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (rdy != 2'b00) leak = 1'b1;
            if (rsp_valid) begin
                t  = cyc;
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Called at a negedge with rsp_valid high: handshake on the next edge.
    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic do_txn(input int s, input logic [1:0] o, input logic wd,
                          input logic [XLEN-1:0] x, input logic [XLEN-1:0] y, input logic [TAG_W-1:0] t,
                          output logic [XLEN-1:0] d, output logic ds, output logic [TAG_W-1:0] dt,
                          output int lat, output logic ok);
        int t0, t1;
        logic got, leak;
        d = '0; ds = 1'b0; dt = '0; lat = -1;
        @(posedge clk);
        #1;
        op_i[s] = o; w_i[s] = wd; a_i[s] = x; b_i[s] = y; tag_i[s] = t; v[s] = 1'b1;
        wait_accept(s, t0, got);
        @(posedge clk);
        #1 v[s] = 1'b0;
        ok = got;
        if (!got) return;
        last_served = s;
        wait_rsp(t1, got, leak);
        ok = got;
        if (!got) return;
        lat = t1 - t0; d = rsp_data; ds = rsp_src; dt = rsp_tag;
        finish_rsp();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; v = 2'b11; flush = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, core_mul_valid, rdy} !== 4'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b expected 0000", {rsp_valid, core_mul_valid, rdy});
        end
        checks++;
        if ({rsp_data, rsp_src, rsp_tag} !== '0) begin
            failures++; $display("FAIL reset_rsp: got data=%h src=%b tag=%h expected zeros", rsp_data, rsp_src, rsp_tag);
        end
        checks++;
        if ({core_multiplicand, core_multiplier} !== '0) begin
            failures++; $display("FAIL reset_core_regs: got %h %h expected zeros", core_multiplicand, core_multiplier);
        end
        @(posedge clk);
        #1 v = 2'b00; rst_n = 1'b1;
    endtask

    task automatic test_latency();
        logic [XLEN-1:0] d; logic ds; logic [TAG_W-1:0] dt; int lat; logic ok; int p0;
        p0 = pulses;
        do_txn(0, 2'b00, 1'b0, 64'd3, 64'd5, 4'd7, d, ds, dt, lat, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL lat_handshake: timed out"); end
        checks++;
        if (d !== 64'd15 || ds !== 1'b0 || dt !== 4'd7) begin
            failures++; $display("FAIL lat_result: got %h/%b/%h expected f/0/7", d, ds, dt);
        end
        checks++;
        if (lat !== RSP_LAT) begin failures++; $display("FAIL lat_cycles: got %0d expected %0d", lat, RSP_LAT); end
        checks++;
        if (pulses - p0 !== 1) begin failures++; $display("FAIL lat_pulses: got %0d expected 1", pulses - p0); end
    endtask

    task automatic test_arith();
        logic [1:0]      dop [7] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b01};
        logic            dw  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [XLEN-1:0] da  [7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                     64'h8000_0000_0000_0000, 64'h0000_0000_7FFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD,
                                     64'hFFFF_FFFF_FFFF_FFFF};
        logic [XLEN-1:0] db  [7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF,
                                     64'h8000_0000_0000_0000, 64'd2, 64'd5, 64'd3};
        logic [XLEN-1:0] dx  [7] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE,
                                     64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF1,
                                     64'hFFFF_FFFF_FFFF_FFFD};
        logic [XLEN-1:0] d, x, y, e; logic ds; logic [TAG_W-1:0] dt, t; int lat, s; logic ok, wd; logic [1:0] o;
        for (int i = 0; i < 7; i++) begin
            s = i % 2;
            do_txn(s, dop[i], dw[i], da[i], db[i], 4'(i), d, ds, dt, lat, ok);
            checks++;
            if (!ok || d !== dx[i] || ds !== 1'(s) || dt !== 4'(i) || lat !== RSP_LAT) begin
                failures++;
                $display("FAIL arith_dir%0d: got ok=%b data=%h src=%b tag=%h lat=%0d expected data=%h src=%0d tag=%0d lat=%0d",
                         i, ok, d, ds, dt, lat, dx[i], s, i, RSP_LAT);
            end
        end
        for (int i = 0; i < 16; i++) begin
            s = $urandom_range(0, 1);
            o = 2'($urandom_range(0, 3)); wd = ($urandom_range(0, 3) == 0);
            x = rand_operand(); y = rand_operand(); t = 4'($urandom_range(0, 15));
            e = ref_mul(o, wd, x, y);
            do_txn(s, o, wd, x, y, t, d, ds, dt, lat, ok);
            checks++;
            if (!ok || d !== e || ds !== 1'(s) || dt !== t) begin
                failures++;
                $display("FAIL arith_rand%0d: op=%0d w=%b a=%h b=%h got ok=%b data=%h src=%b tag=%h expected data=%h src=%0d tag=%h",
                         i, o, wd, x, y, ok, d, ds, dt, e, s, t);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_s, got_s, t1, p0; logic ok, leak, found;
        logic [XLEN-1:0] exp_d; logic [TAG_W-1:0] exp_t;
        @(posedge clk);
        #1 rand_req(0); rand_req(1); v = 2'b11;
        for (int k = 0; k < 6; k++) begin
            exp_s = 1 - last_served;
            found = 1'b0;
            for (int i = 0; i < TMO && !found; i++) begin
                @(negedge clk);
                if (rdy != 2'b00) found = 1'b1;
            end
            checks++;
            if (rdy !== 2'(1 << exp_s)) begin
                failures++; $display("FAIL rr_grant%0d: got ready=%b expected %b", k, rdy, 2'(1 << exp_s));
            end
            got_s = rdy[1] ? 1 : 0;
            exp_d = ref_mul(op_i[got_s], w_i[got_s], a_i[got_s], b_i[got_s]);
            exp_t = tag_i[got_s];
            last_served = got_s;
            p0 = pulses;
            @(posedge clk);
            #1 rand_req(got_s);
            wait_rsp(t1, ok, leak);
            checks++;
            if (!ok || leak) begin
                failures++; $display("FAIL rr_busy%0d: got ok=%b ready_leak=%b expected ok=1 ready_leak=0", k, ok, leak);
            end
            checks++;
            if (rsp_data !== exp_d || rsp_src !== 1'(got_s) || rsp_tag !== exp_t) begin
                failures++; $display("FAIL rr_rsp%0d: got %h/%b/%h expected %h/%0d/%h", k, rsp_data, rsp_src, rsp_tag, exp_d, got_s, exp_t);
            end
            if (ok) finish_rsp();
            checks++;
            if (pulses - p0 !== 1) begin failures++; $display("FAIL rr_pulses%0d: got %0d expected 1", k, pulses - p0); end
        end
        v = 2'b00;
    endtask

    task automatic test_flush();
        int t0, t1, t2, p0, o0; logic ok, leak, seen;
        logic [XLEN-1:0] exp_d; logic [TAG_W-1:0] exp_t;
        p0 = pulses; o0 = overlaps; t1 = 0;
        @(posedge clk);
        #1 rand_req(0); flush = 1'b1; v[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy !== 2'b00) begin failures++; $display("FAIL flush_idle: got ready=%b expected 00", rdy); end
        @(posedge clk);
        #1 flush = 1'b0;
        wait_accept(0, t0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL flush_accept: timed out"); end
        @(posedge clk);
        #1 rand_req(0);
        last_served = 0;
        exp_d = ref_mul(op_i[0], w_i[0], a_i[0], b_i[0]);
        exp_t = tag_i[0];
        while (cyc < t0 + 19) @(negedge clk);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        seen = 1'b0; ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
            if (v[0] && rdy[0]) begin t1 = cyc; ok = 1'b1; break; end
        end
        checks++;
        if (seen) begin failures++; $display("FAIL flush_no_rsp: got rsp_valid=1 expected 0"); end
        checks++;
        if (!ok || t1 < t0 + RSP_LAT) begin
            failures++; $display("FAIL flush_next_accept: got ok=%b at +%0d expected >= +%0d", ok, t1 - t0, RSP_LAT);
        end
        checks++;
        if (overlaps !== o0) begin failures++; $display("FAIL flush_overlap: got %0d extra pulses while busy expected 0", overlaps - o0); end
        @(posedge clk);
        #1 v[0] = 1'b0;
        wait_rsp(t2, ok, leak);
        checks++;
        if (!ok || rsp_data !== exp_d || rsp_tag !== exp_t || t2 - t1 !== RSP_LAT) begin
            failures++; $display("FAIL flush_after: got ok=%b data=%h tag=%h lat=%0d expected %h/%h/%0d", ok, rsp_data, rsp_tag, t2 - t1, exp_d, exp_t, RSP_LAT);
        end
        if (ok) finish_rsp();
        checks++;
        if (pulses - p0 !== 2) begin failures++; $display("FAIL flush_pulses: got %0d expected 2", pulses - p0); end
    endtask

    task automatic test_flush_resp();
        int t0, t1; logic ok, leak;
        @(posedge clk);
        #1 rand_req(1); v[1] = 1'b1;
        wait_accept(1, t0, ok);
        @(posedge clk);
        #1 v[1] = 1'b0;
        last_served = 1;
        wait_rsp(t1, ok, leak);
        checks++;
        if (!ok) begin failures++; $display("FAIL flush_resp_wait: timed out"); end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL flush_resp_drop: got rsp_valid=%b expected 0", rsp_valid); end
    endtask

    task automatic test_stall();
        int t0, t1; logic ok, leak, stable;
        logic [XLEN-1:0] exp_d; logic [TAG_W-1:0] exp_t;
        @(posedge clk);
        #1 rand_req(0); v[0] = 1'b1;
        exp_d = ref_mul(op_i[0], w_i[0], a_i[0], b_i[0]);
        exp_t = tag_i[0];
        wait_accept(0, t0, ok);
        @(posedge clk);
        #1 v[0] = 1'b0;
        last_served = 0;
        wait_rsp(t1, ok, leak);
        stable = ok;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_src !== 1'b0 || rsp_tag !== exp_t || rdy !== 2'b00)
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            failures++; $display("FAIL stall_hold: got v=%b %h/%b/%h expected 1 %h/0/%h", rsp_valid, rsp_data, rsp_src, rsp_tag, exp_d, exp_t);
        end
        finish_rsp();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL stall_release: got rsp_valid=%b expected 0", rsp_valid); end
    endtask

    task automatic test_reset_busy();
        logic [XLEN-1:0] d; logic ds; logic [TAG_W-1:0] dt; int lat, t0; logic ok;
        do_txn(0, 2'b00, 1'b0, 64'd9, 64'd9, 4'd3, d, ds, dt, lat, ok);
        checks++;
        if (!ok || d !== 64'd81) begin failures++; $display("FAIL rb_pre: got ok=%b data=%h expected 51", ok, d); end
        @(posedge clk);
        #1 op_i[0] = 2'b00; w_i[0] = 1'b0; a_i[0] = 64'd123; b_i[0] = 64'd456; tag_i[0] = 4'd9; v[0] = 1'b1;
        wait_accept(0, t0, ok);
        @(posedge clk);
        #1 v[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, core_mul_valid, rdy} !== 4'b0 || {rsp_data, rsp_src, rsp_tag} !== '0) begin
            failures++; $display("FAIL rb_reset_out: got ctrl=%b data=%h src=%b tag=%h expected zeros",
                                 {rsp_valid, core_mul_valid, rdy}, rsp_data, rsp_src, rsp_tag);
        end
        checks++;
        if ({core_multiplicand, core_multiplier} !== '0) begin
            failures++; $display("FAIL rb_reset_core: got %h %h expected zeros", core_multiplicand, core_multiplier);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        last_served = 1;
        do_txn(0, 2'b00, 1'b0, 64'd6, 64'd7, 4'd5, d, ds, dt, lat, ok);
        checks++;
        if (!ok || d !== 64'd42 || dt !== 4'd5 || lat !== RSP_LAT) begin
            failures++; $display("FAIL rb_post: got ok=%b data=%h tag=%h lat=%0d expected 2a/5/%0d", ok, d, dt, lat, RSP_LAT);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            op_i[s] = '0; w_i[s] = 1'b0; a_i[s] = '0; b_i[s] = '0; tag_i[s] = '0;
        end
        test_reset();
        test_latency();
        test_arith();
        test_round_robin();
        test_flush();
        test_flush_resp();
        test_stall();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
